// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel types shared by the arbiter and its bench.
package tlul_pkg;

    // Host-to-device: A channel request plus the host's D channel ready.
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    // Device-to-host: D channel response plus the device's A channel ready.
    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_arb_nto1.sv
// N-to-1 TL-UL arbiter. Merges NumHosts request channels onto one device
// port, remembers the issuing host of every in-flight request in a small
// index FIFO and steers in-order device responses back to that host.
// Optional per-host grant counters: define TLUL_ARB_NTO1_PERF_CNT_EN.
module tlul_arb_nto1 #(
    parameter int unsigned NumHosts       = 2,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned RoundRobin     = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  tlul_pkg::tl_h2d_t tl_h_i [NumHosts],
    output tlul_pkg::tl_d2h_t tl_h_o [NumHosts],
    output tlul_pkg::tl_h2d_t tl_d_o,
    input  tlul_pkg::tl_d2h_t tl_d_i
`ifdef TLUL_ARB_NTO1_PERF_CNT_EN
    ,
    output logic [NumHosts-1:0][15:0] grant_cnt_o
`endif
);

    localparam int unsigned IdxW = $clog2(NumHosts);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic [NumHosts-1:0] req;
    logic [IdxW-1:0]     arb_idx;
    logic                arb_found;
    logic [IdxW:0]       rr_sum;
    logic [IdxW-1:0]     gnt_idx;
    logic                gnt_valid;

    logic [IdxW-1:0]     idx_mem_q [MaxOutstanding];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                lock_q, lock_d;
    logic [IdxW-1:0]     lock_idx_q, lock_idx_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;

    logic                full, empty;
    logic                dev_a_valid, dev_d_ready;
    logic                push, pop;
    logic [IdxW-1:0]     head_idx;

    // Gather the per-host request bits.
    for (genvar gi = 0; gi < NumHosts; gi++) begin : g_req
        assign req[gi] = tl_h_i[gi].a_valid;
    end

    // Pick the first requester, starting at the round-robin pointer or at host 0.
    always_comb begin
        arb_idx   = '0;
        arb_found = 1'b0;
        rr_sum    = '0;
        for (int i = 0; i < int'(NumHosts); i++) begin
            if (RoundRobin != 0) begin
                rr_sum = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
                if (rr_sum >= (IdxW+1)'(NumHosts)) begin
                    rr_sum = rr_sum - (IdxW+1)'(NumHosts);
                end
            end else begin
                rr_sum = (IdxW+1)'(i);
            end
            if (!arb_found && req[rr_sum[IdxW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = rr_sum[IdxW-1:0];
            end
        end
    end

    // A stalled request keeps its grant, so the A channel never switches mid-transfer.
    assign gnt_idx   = lock_q ? lock_idx_q : arb_idx;
    assign gnt_valid = req[gnt_idx];

    assign full     = (cnt_q == CntW'(MaxOutstanding));
    assign empty    = (cnt_q == '0);
    assign head_idx = idx_mem_q[rd_ptr_q];

    // Outputs are gated by rst_ni directly so they fall the instant reset asserts.
    assign dev_a_valid = rst_ni && gnt_valid && !full;
    assign dev_d_ready = rst_ni && !empty && tl_h_i[head_idx].d_ready;
    assign push        = dev_a_valid && tl_d_i.a_ready;
    assign pop         = tl_d_i.d_valid && dev_d_ready;

    // Forward the granted host's A channel to the device unchanged.
    always_comb begin
        tl_d_o         = tl_h_i[gnt_idx];
        tl_d_o.a_valid = dev_a_valid;
        tl_d_o.d_ready = dev_d_ready;
    end

    // Broadcast the response payload; valid/ready only reach the owning host.
    always_comb begin
        for (int h = 0; h < int'(NumHosts); h++) begin
            tl_h_o[h]         = tl_d_i;
            tl_h_o[h].a_ready = push && (gnt_idx == IdxW'(h));
            tl_h_o[h].d_valid = rst_ni && !empty && tl_d_i.d_valid && (head_idx == IdxW'(h));
        end
    end

    // Next-state for FIFO pointers, occupancy, grant lock and round-robin pointer.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (push) begin
            lock_d = 1'b0;
        end else if (dev_a_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = gnt_idx;
        end
        if (push && (RoundRobin != 0)) begin
            rr_ptr_d = (gnt_idx == IdxW'(NumHosts - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Control state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Index storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            idx_mem_q[wr_ptr_q] <= gnt_idx;
        end
    end

`ifdef TLUL_ARB_NTO1_PERF_CNT_EN
    for (genvar gi = 0; gi < NumHosts; gi++) begin : g_perf
        logic [15:0] grant_cnt_q;

        // Count accepted requests per host, sticking at the maximum.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                grant_cnt_q <= '0;
            end else if (push && (gnt_idx == IdxW'(gi)) && (grant_cnt_q != 16'hFFFF)) begin
                grant_cnt_q <= grant_cnt_q + 16'd1;
            end
        end

        assign grant_cnt_o[gi] = grant_cnt_q;
    end
`endif

endmodule

// File: doc/tlul_arb_nto1.md
TLUL_ARB_NTO1 -- requirements
Module: tlul_arb_nto1

Interface
REQ-001 SHALL have parameter NumHosts, default 2; number of TL-UL host ports (legal 2..8).
REQ-002 SHALL have parameter MaxOutstanding, default 4; in-flight request limit (legal 1..16).
REQ-003 SHALL have parameter RoundRobin, default 1; 1 = round-robin arbitration, 0 = fixed priority with lowest index winning.
REQ-004 SHALL have port clk_i  input  1  the only clock; one clock, all state on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port tl_h_i  input  NumHosts x tlul_pkg::tl_h2d_t  host request channels.
REQ-007 SHALL have port tl_h_o  output  NumHosts x tlul_pkg::tl_d2h_t  host response channels.
REQ-008 SHALL have port tl_d_o  output  tlul_pkg::tl_h2d_t  merged request to device.
REQ-009 SHALL have port tl_d_i  input  tlul_pkg::tl_d2h_t  device response.

Function
REQ-010 SHALL present the winning host's A channel to tl_d_o combinationally, with zero added latency.
REQ-011 SHALL keep a host-index FIFO of depth MaxOutstanding with an occupancy counter of width $clog2(MaxOutstanding+1).
REQ-012 SHALL drive tl_d_o.a_valid=0 and all host a_ready=0 while the FIFO is full; push is never granted in a full cycle, even if a pop occurs in the same cycle.
REQ-013 SHALL assert a_ready only to the granted host, and only when the device asserts a_ready and the FIFO is not full.
REQ-014 SHALL push the granted index into the FIFO on every tl_d_o a_valid&&a_ready handshake.
REQ-015 SHALL lock the grant in a register when a_valid=1 and a_ready=0, holding the same host until its handshake completes; no re-arbitration while locked.
REQ-016 SHALL keep a round-robin pointer when RoundRobin=1; after a handshake by host k, the pointer becomes (k+1) mod NumHosts and the search starts at the pointer, wrapping.
REQ-017 SHALL route tl_d_i only to the host at the FIFO head (d_valid to that host, 0 to others) and take d_ready from that host.
REQ-018 SHALL pop the FIFO on a device d_valid&&d_ready handshake.
REQ-019 SHALL drive tl_d_o.d_ready=0 and drop any device response that arrives while the FIFO is empty; the protocol does not allow this case.
REQ-020 SHALL handle a push and a pop in the same cycle with the occupancy unchanged and correct pointer wrap-around.
REQ-021 SHALL depend on the device returning responses in request order.
REQ-022 SHALL forward a_source unmodified.

Reset
REQ-023 SHALL reset asynchronously on rst_ni low, with no dependence on the clock: FIFO empty, occupancy 0, grant unlocked, round-robin pointer 0.
REQ-024 SHALL hold tl_d_o.a_valid=0, tl_d_o.d_ready=0, all host a_ready=0 and all host d_valid=0 while in reset.
REQ-025 SHALL discard any transactions that are in flight when reset asserts mid-operation; the first cycle after deassertion behaves as an idle start.

Configuration
REQ-026 SHALL compile in, when macro TLUL_ARB_NTO1_PERF_CNT_EN is defined, output grant_cnt_o (NumHosts x 16 bits): a per-host count of accepted requests that saturates at 0xFFFF and resets to 0.
REQ-027 SHALL, when TLUL_ARB_NTO1_PERF_CNT_EN is undefined, have no grant_cnt_o port and no counter logic, with all other behaviour identical.

Verification
REQ-028 SHALL cover: hosts 0 and 1 request every cycle, RoundRobin=1, device always ready -> grants alternate 0,1,0,1 and responses return to the issuing host.
REQ-029 SHALL cover: RoundRobin=0, both hosts request continuously -> host 0 is granted every cycle and host 1 never.
REQ-030 SHALL cover: host 1 granted, device a_ready low for 3 cycles, host 0 raises a_valid meanwhile -> host 1 stays granted until its handshake.
REQ-031 SHALL cover: MaxOutstanding=4, device withholds responses -> exactly 4 requests accepted, a_ready=0 on the 5th; after one response, a_ready=1 on the next cycle.
REQ-032 SHALL cover: push and pop in the same cycle at occupancy 2 -> occupancy remains 2; run 20 transactions to check wrap-around routing.
REQ-033 SHALL cover: reset asserted with 3 outstanding -> all outputs 0 immediately; after release, the first request is granted with an empty FIFO, and with PERF_CNT the counters read 0.
